// File: rtl/stuff_serial_tx.sv
// Bit-stuffing serial transmitter: words go out LSB first, bit0 one cycle after accept, with a 0
// forced after RUN_LEN consecutive 1s; din_ready only opens at a word boundary or while idle.
module stuff_serial_tx #(
  parameter int DATA_W  = 8,
  parameter int RUN_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              stuff_pulse,
  output logic              busy
);

  localparam int ONES_W = $clog2(RUN_LEN + 1);
  localparam int IDX_W  = $clog2(DATA_W + 1);

  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(RUN_LEN);
  localparam logic [ONES_W-1:0] ONES_ONE = ONES_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic              last_q, last_d;
  logic              tx_bit_q, tx_bit_d;
  logic              tx_valid_q, tx_valid_d;
  logic              stuff_q, stuff_d;

  logic              word_done;
  logic              run_full;
  logic              accept;
  logic [ONES_W-1:0] load_ones;
  logic [ONES_W-1:0] emit_ones;

  assign word_done = (idx_q == IDX_LAST);
  assign run_full  = (ones_q == ONES_MAX);

  // The run count carries into the next word, so a loaded bit0 extends the current run.
  assign load_ones = din[0]     ? (ones_q + ONES_ONE) : '0;
  assign emit_ones = shreg_q[0] ? (ones_q + ONES_ONE) : '0;

  always_comb begin
    din_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE:    din_ready = 1'b1;
        SHIFT:   din_ready = word_done && !run_full;
        STUFF:   din_ready = last_q;
        default: din_ready = 1'b0;
      endcase
    end
  end

  assign accept = din_valid & din_ready;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    ones_d     = ones_q;
    last_d     = last_q;
    tx_bit_d   = tx_bit_q;
    tx_valid_d = tx_valid_q;
    stuff_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = SHIFT;
          shreg_d    = din >> 1;
          tx_bit_d   = din[0];
          tx_valid_d = 1'b1;
          idx_d      = IDX_ONE;
          ones_d     = load_ones;
          last_d     = 1'b0;
        end
      end

      SHIFT: begin
        if (run_full) begin
          state_d  = STUFF;
          tx_bit_d = 1'b0;
          stuff_d  = 1'b1;
          ones_d   = '0;
          last_d   = word_done;
        end else if (!word_done) begin
          tx_bit_d   = shreg_q[0];
          shreg_d    = shreg_q >> 1;
          idx_d      = idx_q + IDX_ONE;
          ones_d     = emit_ones;
          tx_valid_d = 1'b1;
        end else if (accept) begin
          shreg_d    = din >> 1;
          tx_bit_d   = din[0];
          tx_valid_d = 1'b1;
          idx_d      = IDX_ONE;
          ones_d     = load_ones;
          last_d     = 1'b0;
        end else begin
          state_d    = IDLE;
          tx_bit_d   = 1'b0;
          tx_valid_d = 1'b0;
          idx_d      = '0;
          ones_d     = '0;
          last_d     = 1'b0;
        end
      end

      STUFF: begin
        if (!last_q) begin
          state_d    = SHIFT;
          tx_bit_d   = shreg_q[0];
          shreg_d    = shreg_q >> 1;
          idx_d      = idx_q + IDX_ONE;
          ones_d     = emit_ones;
          tx_valid_d = 1'b1;
        end else if (accept) begin
          state_d    = SHIFT;
          shreg_d    = din >> 1;
          tx_bit_d   = din[0];
          tx_valid_d = 1'b1;
          idx_d      = IDX_ONE;
          ones_d     = load_ones;
          last_d     = 1'b0;
        end else begin
          state_d    = IDLE;
          tx_bit_d   = 1'b0;
          tx_valid_d = 1'b0;
          idx_d      = '0;
          ones_d     = '0;
          last_d     = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        tx_bit_d   = 1'b0;
        tx_valid_d = 1'b0;
        idx_d      = '0;
        ones_d     = '0;
        last_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      ones_q     <= '0;
      last_q     <= 1'b0;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      stuff_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      ones_q     <= ones_d;
      last_q     <= last_d;
      tx_bit_q   <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
      stuff_q    <= stuff_d;
    end
  end

  assign tx_bit      = tx_bit_q;
  assign tx_valid    = tx_valid_q;
  assign stuff_pulse = stuff_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/stuff_serial_tx.md
Name: stuff_serial_tx

Overview:
Serial bit-stuffing transmitter. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock, LSB first. After RUN_LEN consecutive 1s it inserts a 0, so the line never carries RUN_LEN+1 consecutive 1s. This keeps the line free of the run-of-ones marker that the downstream serial run detector flags.

Parameters:
DATA_W, 8, width of each parallel input word (>=2)
RUN_LEN, 3, maximum consecutive 1s allowed on the line before a stuffed 0 (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
din  input  DATA_W  parallel word to transmit
din_valid  input  1  din holds a word
din_ready  output  1  block accepts din this cycle
tx_bit  output  1  serial line bit, registered
tx_valid  output  1  tx_bit is a data or stuff bit, registered
stuff_pulse  output  1  high for exactly the cycles where tx_bit is a stuffed 0, registered
busy  output  1  state != IDLE

Behaviour:
- Reset: synchronous, active-high reset rst; clock clk.
  - While rst=1: state<=IDLE, tx_bit<=0, tx_valid<=0, stuff_pulse<=0, ones_cnt<=0, bit_idx<=0.
  - din_ready is forced 0 while rst=1.
- Reset mid-frame aborts the word. No further bits are emitted and the partial word is lost.
- States:
  - IDLE: line idles at tx_bit=0, tx_valid=0.
  - SHIFT: tx_bit is a data bit.
  - STUFF: tx_bit is a stuffed 0.
- Accept: a word is taken on any edge where din_valid&din_ready=1.
  - At that edge: shift register <= din; tx_bit<=din[0]; tx_valid<=1; bit_idx<=1; state<=SHIFT.
  - Latency: bit0 is on the line in the cycle right after the accepting edge.
- ones_cnt counts consecutive 1s currently on the line, including the present tx_bit.
  - Updated with each emitted bit: 1 -> ones_cnt+1, 0 -> ones_cnt=0.
  - A stuff bit clears it.
  - It carries across back-to-back words. Entering IDLE clears it, because the idle line is 0.
- SHIFT, on each edge:
  - If ones_cnt==RUN_LEN: go to STUFF (tx_bit<=0, stuff_pulse<=1, ones_cnt<=0). Record last_flag=1 if bit_idx==DATA_W.
  - Else if bit_idx<DATA_W: emit din_word[bit_idx], bit_idx++.
  - Else (word done, no stuff): a new accept goes to SHIFT of the new word; otherwise go to IDLE (tx_valid<=0, tx_bit<=0).
- STUFF, on each edge:
  - If last_flag=0: resume SHIFT with the next data bit.
  - If last_flag=1: take a new accept, or go to IDLE.
  - STUFF always lasts exactly 1 cycle.
- din_ready (combinational, rst gated) is high in any of these cases:
  - state==IDLE
  - state==SHIFT with bit_idx==DATA_W and ones_cnt!=RUN_LEN
  - state==STUFF with last_flag=1
- This gives zero-gap back-to-back streaming: no idle cycle between words when din_valid stays high.
- din is sampled only at the accepting edge. Changes to din afterwards have no effect.
- Throughput: a word takes DATA_W plus the number of stuff bits cycles.
- Width rules:
  - ones_cnt is clog2(RUN_LEN+1) bits and never exceeds RUN_LEN.
  - bit_idx is clog2(DATA_W+1) bits.
- Invariant: no RUN_LEN+1 consecutive cycles with tx_valid=1 and tx_bit=1.
- din_valid while din_ready=0 is held off. The upstream keeps din stable until accepted.

Test Plan:
- 0xA5, single word, defaults -> tx_bit 1,0,1,0,0,1,0,1 over 8 cycles, tx_valid=1 throughout, stuff_pulse never high, then IDLE with tx_bit=0.
- 0xFF -> 1,1,1,0s,1,1,1,0s,1,1 (s = stuff_pulse=1), 10 cycles, ends with ones_cnt=2 then IDLE.
- 0xE0 -> 0,0,0,0,0,1,1,1,0s, 9 cycles. din_ready=1 only in the stuff cycle; a second word given then starts on the next cycle with no gap.
- 0xFF then 0x01 back-to-back with din_valid held -> ...,1,1 (end of word 1), then 1,0s,0,0,0,0,0,0,0. The run carries across the word boundary and there is no idle cycle between words.
- rst asserted at bit 4 of 0xFF -> next cycle tx_valid=0, tx_bit=0, busy=0; din_ready=0 while rst is held, 1 the cycle after release. A fresh 0x0F is then sent cleanly as 1,1,1,0s,1,0,0,0,0.
- 200 random words with random din_valid gaps, RUN_LEN=3 and RUN_LEN=1:
  - monitor never sees RUN_LEN+1 consecutive valid 1s;
  - de-stuffed stream equals the input words in order;
  - cycle count per word equals DATA_W plus stuff_pulse count.
